// File: rtl/dummy_arbiter.sv
// Round-robin arbiter sharing one dummy datapath among NUM_REQ requesters.
// Define DUMMY_ARBITER_BURST_EN to allow up to BURST_LEN back-to-back grants.
module dummy_arbiter #(
  parameter int DATA_W    = 128,
  parameter int NUM_REQ   = 4,
  parameter int LATENCY   = 1,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  output logic                      idle_o,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [DATA_W-1:0]         dp_data_o,
  input  logic [DATA_W-1:0]         dp_data_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o
);

  localparam int PW = $clog2(NUM_REQ);
  // Also counts the item whose response is on the bus this cycle.
  localparam int CW = $clog2(LATENCY + 3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t             r_state;
  logic               r_idle;
  logic [PW-1:0]      r_ptr;
  logic [DATA_W-1:0]  r_dp;
  logic [NUM_REQ-1:0] r_tag [0:LATENCY];
  logic [NUM_REQ-1:0] r_rsp;
  logic [CW-1:0]      r_cnt;

  logic               w_found;
  logic [PW-1:0]      w_j;
  logic [PW-1:0]      w_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_rsp_any;
  logic [CW-1:0]      w_cnt_nxt;
  logic [PW-1:0]      w_idx_inc;
  logic [PW-1:0]      w_ptr_inc;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(NUM_REQ - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_idx   = r_ptr;
    w_j     = r_ptr;
    w_grant = '0;
    if (r_state == S_RUN && enable_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_j = PW'((int'(r_ptr) + k) % NUM_REQ);
        if (!w_found && req_valid_i[w_j]) begin
          w_found = 1'b1;
          w_idx   = w_j;
        end
      end
    end
    if (w_found) begin
      w_grant[w_idx] = 1'b1;
    end
  end

  assign w_rsp_any = |r_rsp;
  assign w_idx_inc = wrap_inc(w_idx);
  assign w_ptr_inc = wrap_inc(r_ptr);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_found && !w_rsp_any) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (!w_found && w_rsp_any) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

`ifdef DUMMY_ARBITER_BURST_EN
  localparam int BW = $clog2(BURST_LEN + 1);

  logic [BW-1:0] r_burst;
  logic [BW-1:0] w_burst_nxt;

  assign w_burst_nxt =
    (r_burst != '0 && w_idx == r_ptr) ?
    r_burst + BW'(1) : BW'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr   <= '0;
      r_burst <= '0;
    end else if (w_found) begin
      if (w_burst_nxt == BW'(BURST_LEN)) begin
        r_ptr   <= w_idx_inc;
        r_burst <= '0;
      end else begin
        r_ptr   <= w_idx;
        r_burst <= w_burst_nxt;
      end
    end else if (r_burst != '0) begin
      r_ptr   <= w_ptr_inc;
      r_burst <= '0;
    end
  end
`else
  logic w_unused_burst;
  assign w_unused_burst = ^BURST_LEN ^ ^w_ptr_inc;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_idx_inc;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_idle  <= 1'b1;
      r_dp    <= '0;
      r_rsp   <= '0;
      r_cnt   <= '0;
      for (int j = 0; j <= LATENCY; j++) begin
        r_tag[j] <= '0;
      end
    end else begin
      if (w_found) begin
        r_dp <= req_data_i[int'(w_idx)*DATA_W +: DATA_W];
      end
      r_tag[0] <= w_grant;
      for (int j = 1; j <= LATENCY; j++) begin
        r_tag[j] <= r_tag[j-1];
      end
      r_rsp <= r_tag[LATENCY];
      r_cnt <= w_cnt_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_state <= S_RUN;
            r_idle  <= 1'b0;
          end
        end
        S_RUN: begin
          if (!enable_i) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (enable_i) begin
            r_state <= S_RUN;
          end else if (w_cnt_nxt == '0) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign idle_o      = r_idle;
  assign req_ready_o = w_grant;
  assign dp_data_o   = r_dp;
  assign rsp_valid_o = r_rsp;
  assign rsp_data_o  = w_rsp_any ? dp_data_i : '0;

endmodule

// File: tb/tb_dummy_arbiter.sv
// Bench for dummy_arbiter: directed table, drain/reset sequences,
// then random traffic against a queue-based reference model.
module tb_dummy_arbiter;

  localparam int W   = 128;
  localparam int N   = 4;
  localparam int LAT = 1;
  localparam int BL  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_i;
  logic           enable_i;
  logic           idle_o;
  logic [N-1:0]   req_valid_i;
  logic [N-1:0]   req_ready_o;
  logic [N*W-1:0] req_data_i;
  logic [W-1:0]   dp_data_o;
  logic [W-1:0]   dp_data_i;
  logic [N-1:0]   rsp_valid_o;
  logic [W-1:0]   rsp_data_o;

  logic [W-1:0] dat [N];
  for (genvar g = 0; g < N; g++) begin : g_dat
    assign req_data_i[g*W +: W] = dat[g];
  end

  // Datapath stand-in: one register stage that inverts its input.
  logic [W-1:0] r_dmy;
  always @(posedge clk) r_dmy <= ~dp_data_o;
  assign dp_data_i = r_dmy;

  dummy_arbiter #(
    .DATA_W(W), .NUM_REQ(N),
    .LATENCY(LAT), .BURST_LEN(BL)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .enable_i(enable_i),
    .idle_o(idle_o),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_data_i(req_data_i),
    .dp_data_o(dp_data_o),
    .dp_data_i(dp_data_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_data_o(rsp_data_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int tag;
    int due;
  } fl_t;

  fl_t          q[$];
  int           m_st;
  int           m_ptr;
  int           m_own;
  int           m_run;
  logic [W-1:0] m_dp;
  int           cyc;

  function automatic int pick(input logic [N-1:0] v);
    for (int o = 0; o < N; o++) begin
      if (v[(m_ptr + o) % N]) return (m_ptr + o) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_st  = 0;
    m_ptr = 0;
    m_own = 0;
    m_run = 0;
    m_dp  = '0;
    q.delete();
  endtask

  task automatic check_all();
    int g;
    logic [N-1:0] xr;
    logic [N-1:0] xs;
    g  = (m_st == 1 && enable_i) ? pick(req_valid_i) : -1;
    xr = '0;
    xs = '0;
    if (g >= 0) xr[g] = 1'b1;
    if (q.size() > 0 && q[0].due == cyc) xs[q[0].tag] = 1'b1;
    chk("ready", W'(req_ready_o), W'(xr));
    chk("idle", W'(idle_o), W'(m_st == 0));
    chk("dp_data", dp_data_o, m_dp);
    chk("rsp_valid", W'(rsp_valid_o), W'(xs));
    chk("rsp_data", rsp_data_o,
        (xs != '0) ? dp_data_i : '0);
  endtask

  task automatic advance();
    int g;
    if (reset_i) begin
      model_reset();
    end else begin
      g = (m_st == 1 && enable_i) ? pick(req_valid_i) : -1;
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{g, cyc + LAT + 2});
        m_dp = dat[g];
      end
`ifdef DUMMY_ARBITER_BURST_EN
      if (g >= 0) begin
        m_run = (m_run > 0 && g == m_own) ? m_run + 1 : 1;
        m_own = g;
        if (m_run == BL) begin
          m_ptr = (g + 1) % N;
          m_run = 0;
        end else begin
          m_ptr = g;
        end
      end else if (m_run > 0) begin
        m_ptr = (m_own + 1) % N;
        m_run = 0;
      end
`else
      if (g >= 0) m_ptr = (g + 1) % N;
`endif
      case (m_st)
        0: if (enable_i) m_st = 1;
        1: if (!enable_i) m_st = 2;
        default: begin
          if (enable_i) m_st = 1;
          else if (q.size() == 0) m_st = 0;
        end
      endcase
    end
    cyc++;
  endtask

  task automatic cb(input logic rst, input logic en,
                    input logic [N-1:0] v);
    reset_i     = rst;
    enable_i    = en;
    req_valid_i = v;
    #1;
    check_all();
  endtask

  task automatic ce();
    advance();
    @(negedge clk);
  endtask

  typedef struct {
    logic         rst;
    logic         en;
    logic [N-1:0] v;
    logic [N-1:0] xr;
    logic         xi;
    logic [N-1:0] xs;
    logic         dchk;
    logic [15:0]  xd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic en,
                     input logic [N-1:0] v,
                     input logic [N-1:0] xr,
                     input logic xi,
                     input logic [N-1:0] xs,
                     input logic dchk,
                     input logic [15:0] xd);
    tbl.push_back('{rst, en, v, xr, xi, xs, dchk, xd});
  endtask

  initial begin
    dat[0] = W'(16'h1000);
    dat[1] = W'(16'h1001);
    dat[2] = W'(16'hA5A5);
    dat[3] = W'(16'h1003);

    // reset, single request from 2
    for (int i = 0; i < 3; i++) add(1, 0, 4'hF, 0, 1, 0, 0, 0);
    add(0, 1, 4'h4, 4'h0, 1, 0, 0, 0);
    add(0, 1, 4'h4, 4'h4, 0, 0, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 0, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 0, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h4, 1, 16'h5A5A);
    // park pointer at 0 via requester 3
    add(0, 1, 4'h8, 4'h8, 0, 0, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 0, 0, 0);
    // fairness: all valid for 8 accepts
`ifdef DUMMY_ARBITER_BURST_EN
    add(0, 1, 4'hF, 4'h1, 0, 4'h0, 0, 0);
    add(0, 1, 4'hF, 4'h1, 0, 4'h8, 1, 16'hEFFC);
    add(0, 1, 4'hF, 4'h1, 0, 4'h0, 0, 0);
    add(0, 1, 4'hF, 4'h1, 0, 4'h1, 0, 0);
    add(0, 1, 4'hF, 4'h2, 0, 4'h1, 0, 0);
    add(0, 1, 4'hF, 4'h2, 0, 4'h1, 0, 0);
    add(0, 1, 4'hF, 4'h2, 0, 4'h1, 0, 0);
    add(0, 1, 4'hF, 4'h2, 0, 4'h2, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h2, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h2, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h2, 0, 0);
`else
    add(0, 1, 4'hF, 4'h1, 0, 4'h0, 0, 0);
    add(0, 1, 4'hF, 4'h2, 0, 4'h8, 1, 16'hEFFC);
    add(0, 1, 4'hF, 4'h4, 0, 4'h0, 0, 0);
    add(0, 1, 4'hF, 4'h8, 0, 4'h1, 0, 0);
    add(0, 1, 4'hF, 4'h1, 0, 4'h2, 0, 0);
    add(0, 1, 4'hF, 4'h2, 0, 4'h4, 0, 0);
    add(0, 1, 4'hF, 4'h4, 0, 4'h8, 0, 0);
    add(0, 1, 4'hF, 4'h8, 0, 4'h1, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h2, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h4, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h8, 0, 0);
`endif
    // wrap/skip: pointer at 3, only 0 and 3 valid
    add(0, 1, 4'h4, 4'h4, 0, 4'h0, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h0, 0, 0);
    add(0, 1, 4'h9, 4'h8, 0, 4'h0, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h4, 1, 16'h5A5A);
    add(0, 1, 4'h9, 4'h1, 0, 4'h0, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h8, 1, 16'hEFFC);
    add(0, 1, 4'h9, 4'h8, 0, 4'h0, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h1, 1, 16'hEFFF);
    add(0, 1, 4'h0, 4'h0, 0, 4'h0, 0, 0);
    add(0, 1, 4'h0, 4'h0, 0, 4'h8, 1, 16'hEFFC);

    reset_i     = 1'b1;
    enable_i    = 1'b0;
    req_valid_i = '1;
    @(negedge clk);
    model_reset();
    cyc = 0;

    foreach (tbl[r]) begin
      cb(tbl[r].rst, tbl[r].en, tbl[r].v);
      chk($sformatf("t%0d_ready", r),
          W'(req_ready_o), W'(tbl[r].xr));
      chk($sformatf("t%0d_idle", r),
          W'(idle_o), W'(tbl[r].xi));
      chk($sformatf("t%0d_rsp", r),
          W'(rsp_valid_o), W'(tbl[r].xs));
      if (tbl[r].rst) chk("rst_dp", dp_data_o, '0);
      if (tbl[r].dchk)
        chk($sformatf("t%0d_rdata", r),
            W'(rsp_data_o[15:0]), W'(tbl[r].xd));
      ce();
    end

    // drain with two items in flight
    cb(0, 1, 4'hF); ce();
    cb(0, 1, 4'hF); ce();
    cb(0, 0, 4'hF);
    chk("drain_ready", W'(req_ready_o), '0);
    ce();
    cb(0, 0, 4'h0);
    chk("drain_rsp1", W'(|rsp_valid_o), W'(1));
    ce();
    cb(0, 0, 4'h0);
    chk("drain_rsp2", W'(|rsp_valid_o), W'(1));
    chk("drain_busy", W'(idle_o), '0);
    ce();
    cb(0, 0, 4'h0);
    chk("drain_idle", W'(idle_o), W'(1));
    ce();
    // re-enable during drain returns to run directly
    cb(0, 1, 4'hF); ce();
    cb(0, 1, 4'hF); ce();
    cb(0, 0, 4'h0); ce();
    cb(0, 1, 4'h0);
    chk("redrain_busy", W'(idle_o), '0);
    ce();
    cb(0, 1, 4'hF);
    chk("rerun_ready", W'(|req_ready_o), W'(1));
    ce();

    // reset one cycle after an accept
    cb(0, 1, 4'hF); ce();
    cb(1, 1, 4'hF); ce();
    for (int i = 0; i < 5; i++) begin
      cb(0, 0, 4'h0);
      chk("rst_norsp", W'(rsp_valid_o), '0);
      chk("rst_idle", W'(idle_o), W'(1));
      ce();
    end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        dat[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      cb(($urandom_range(0, 99) == 0),
         ($urandom_range(0, 7) != 0),
         N'($urandom));
      ce();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
